hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- Tracks every in-flight instruction from EX through WB in a shift-register scoreboard.
- Decodes the ID-stage instruction and produces stall, registered EX forwarding selects, and a multi-cycle MUL busy interlock.
- Generalises fixed-depth forwarding and load-stall logic to a configurable pipeline depth and load latency.

Parameters:
- DEPTH, 3, number of scoreboard slots after ID (slot 0 = EX, slot DEPTH-1 = WB); legal range 2..8.
- LOAD_AVAIL, 2, first slot index from which a LW result can be forwarded; legal range 1..DEPTH-1.
- MUL_LAT, 4, cycles a MUL occupies EX; must be >= 1.
- FWD_W (localparam), $clog2(DEPTH), width of the forwarding select.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_ir  in  32  ID-stage instruction word.
- ex_flush  in  1  kill the ID instruction (taken branch/jump); a bubble enters EX.
- stall  out  1  combinational; hold PC and IF/ID.
- issue  out  1  combinational; the ID instruction enters EX this cycle.
- ex_fwd_a  out  FWD_W  registered; operand A source for the instruction in EX (0 = register file, k = slot k).
- ex_fwd_b  out  FWD_W  registered; operand B source, same encoding.
- ex_busy  out  1  a MUL is still occupying EX.
- wb_wen  out  1  slot DEPTH-1 writes the register file.
- wb_dest  out  5  destination register of slot DEPTH-1.
- stall_count  out  32  saturating count of cycles with stall=1.

Behaviour:
- Decode (op = ir[31:26], funct = ir[5:0]):
  - op 0x00: sources rs, rt; dest rd; wen=1 except funct 0x08 (JR); funct 0x18 is MUL.
  - op 0x23 (LW): source rs; dest rt; load.
  - op 0x08 (ADDI): source rs; dest rt.
  - op 0x2B (SW), op 0x04 (BEQ): sources rs, rt; no write.
  - op 0x03 (JAL): dest 31; no sources.
  - op 0x02 (J): no sources, no write.
  - Any dest of 0 forces wen=0. Register 0 never matches a source. All-zero word is a nop.
- Slot fields: valid, wen, dest, is_load. Reset clears every slot, both fwd selects, busy counter and stall_count. All outputs are 0 after reset.
- Match search: for each source, scan slots j = 0..DEPTH-2, youngest (smallest j) valid wen dest-match wins. Slot DEPTH-1 is never forwarded; the register file is write-before-read.
- Forwarding: with a winning match at j, the select is j+1, registered on issue. On a bubble both selects go to 0.
- Load-use: a winning match with is_load and j+1 < LOAD_AVAIL raises stall.
- stall = id_valid & ~ex_flush & (load-use | ex_busy | no-fwd hazard, see Optional Feature).
- issue = id_valid & ~ex_flush & ~stall.
- Advance when ex_busy=0: slot[i+1] <= slot[i]; slot0 <= decoded ID if issue, else bubble.
- Advance when ex_busy=1: slot0 holds; slot1 <= bubble; slots 2.. shift.
- MUL: on issue of a MUL, busy counter <= MUL_LAT-1. ex_busy = (counter != 0). Counter decrements every cycle while nonzero. MUL_LAT=1 never asserts busy.
- ex_flush and a stall condition in the same cycle: flush wins (stall=0, bubble inserted, instruction dropped).
- Reset mid-MUL: busy counter clears immediately.
- stall_count saturates at 0xFFFFFFFF.

Optional Feature:
- Macro HAZ_FWD_EN.
- Defined: forwarding as described above.
- Undefined: ex_fwd_a/b are tied to 0, and any source match in slots 0..DEPTH-2 stalls until the producer reaches WB. Load-use logic is subsumed.

Decomposition:
- Package hazard_pkg holds:
  - opcode/funct constants (LW, SW, BEQ, ADDI, J, JAL, ALU, JR, MUL);
  - slot_t struct {valid, wen, dest, is_load};
  - decode function returning slot_t plus source-use flags.
- One sub-module, hazard_match: combinational youngest-match search per operand, instantiated twice.

Test Plan:
- ADD r3 in EX, then ADD using r3 in ID -> no stall; next cycle ex_fwd_a=1.
- LW r5 then ADD r6,r5,r5 -> stall=1 one cycle, stall_count=1; ADD issues with ex_fwd_a=ex_fwd_b=2 (DEPTH=3, LOAD_AVAIL=2).
- MUL then ADD (MUL_LAT=4) -> ex_busy high 3 cycles, stall high 3 cycles, slot1 bubbles; ADD issues on the 4th cycle.
- ex_flush asserted together with a load-use stall -> stall=0, issue=0, slot0 bubble; ADD r0 writer never matches.
- Build without HAZ_FWD_EN: ADD r3 then SUB using r3 -> 2 stall cycles, selects stay 0.
- Reset asserted while MUL busy -> next cycle ex_busy=0, wb_wen=0, stall_count=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and decode for the hazard scoreboard.
//   slot_t      - one scoreboard entry (valid, wen, dest, is_load)
//   decode_t    - decoded ID instruction: slot image, MUL flag, source regs/uses
//   hazard_decode() - MIPS subset decode (R-type, LW, SW, ADDI, BEQ, J, JAL)
package hazard_pkg;

   localparam logic [5:0] OP_ALU  = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MUL  = 6'h18;

   typedef struct packed {
      logic       valid;
      logic       wen;
      logic [4:0] dest;
      logic       is_load;
   } slot_t;

   typedef struct packed {
      slot_t      slot;
      logic       is_mul;
      logic       use_rs;
      logic       use_rt;
      logic [4:0] rs;
      logic [4:0] rt;
   } decode_t;

   function automatic decode_t hazard_decode(input logic [31:0] ir);
      decode_t d;
      logic    unused_shamt;
      d            = '0;
      unused_shamt = ^ir[10:6];
      d.slot.valid = 1'b1;
      d.rs         = ir[25:21];
      d.rt         = ir[20:16];
      case (ir[31:26])
         OP_ALU: begin
            d.use_rs    = 1'b1;
            d.use_rt    = 1'b1;
            d.slot.dest = ir[15:11];
            d.slot.wen  = (ir[5:0] != FN_JR);
            d.is_mul    = (ir[5:0] == FN_MUL);
         end
         OP_LW: begin
            d.use_rs       = 1'b1;
            d.slot.dest    = ir[20:16];
            d.slot.wen     = 1'b1;
            d.slot.is_load = 1'b1;
         end
         OP_ADDI: begin
            d.use_rs    = 1'b1;
            d.slot.dest = ir[20:16];
            d.slot.wen  = 1'b1;
         end
         OP_SW, OP_BEQ: begin
            d.use_rs = 1'b1;
            d.use_rt = 1'b1;
         end
         OP_JAL: begin
            d.slot.dest = 5'd31;
            d.slot.wen  = 1'b1;
         end
         default: ;
      endcase
      // r0 is hardwired, so a write to it is no write at all
      if (d.slot.dest == 5'd0) d.slot.wen = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: youngest-producer search for one source operand.
//   slots    in  scoreboard (slot 0 = EX ... slot DEPTH-1 = WB)
//   src      in  source register number
//   use_src  in  the instruction actually reads src
//   hit      out a forwardable producer exists in slots 0..DEPTH-2
//   sel      out forwarding select of the winner (slot index + 1)
//   hit_load out the winner is a load
module hazard_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  slot_t [DEPTH-1:0]         slots,
   input  logic [4:0]                src,
   input  logic                      use_src,
   output logic                      hit,
   output logic [$clog2(DEPTH)-1:0]  sel,
   output logic                      hit_load
);

   // WB slot is covered by the write-before-read register file
   logic unused_wb;
   assign unused_wb = ^slots[DEPTH-1];

   // scan oldest to youngest so the youngest match overwrites the result
   always_comb begin
      hit      = 1'b0;
      sel      = '0;
      hit_load = 1'b0;
      for (int j = DEPTH - 2; j >= 0; j--) begin
         if (use_src && (src != 5'd0) && slots[j].valid && slots[j].wen &&
             (slots[j].dest == src)) begin
            hit      = 1'b1;
            sel      = ($clog2(DEPTH))'(j + 1);
            hit_load = slots[j].is_load;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard/forwarding controller for the in-order MIPS pipe.
//   clock, reset          clock and synchronous active-high reset
//   id_valid, id_ir       ID-stage instruction
//   ex_flush              kill the ID instruction, bubble into EX
//   stall, issue          combinational pipeline control
//   ex_fwd_a, ex_fwd_b    registered operand sources for EX (0 = regfile, k = slot k)
//   ex_busy               multi-cycle MUL occupying EX
//   wb_wen, wb_dest       register-file write from the WB slot
//   stall_count           saturating count of stall cycles
// Build option: HAZ_FWD_EN enables forwarding; without it any producer still
// in slots 0..DEPTH-2 stalls the consumer and the selects stay 0.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int  DEPTH      = 3,
   parameter int  LOAD_AVAIL = 2,
   parameter int  MUL_LAT    = 4,
   localparam int FWD_W      = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [31:0]      id_ir,
   input  logic             ex_flush,
   output logic             stall,
   output logic             issue,
   output logic [FWD_W-1:0] ex_fwd_a,
   output logic [FWD_W-1:0] ex_fwd_b,
   output logic             ex_busy,
   output logic             wb_wen,
   output logic [4:0]       wb_dest,
   output logic [31:0]      stall_count
);

   localparam int BUSY_W = $clog2(MUL_LAT + 1);

   slot_t [DEPTH-1:0] slots_q, slots_d;
   logic [BUSY_W-1:0] busy_q, busy_d;
   logic [FWD_W-1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [31:0]       stall_count_q, stall_count_d;

   decode_t           dec;
   logic              hit_a, hit_b, load_a, load_b, hazard;
   logic [FWD_W-1:0]  sel_a, sel_b, new_fwd_a, new_fwd_b;

   assign dec = hazard_decode(id_ir);

   hazard_match #(.DEPTH(DEPTH)) u_match_a (
      .slots(slots_q), .src(dec.rs), .use_src(dec.use_rs),
      .hit(hit_a), .sel(sel_a), .hit_load(load_a)
   );

   hazard_match #(.DEPTH(DEPTH)) u_match_b (
      .slots(slots_q), .src(dec.rt), .use_src(dec.use_rt),
      .hit(hit_b), .sel(sel_b), .hit_load(load_b)
   );

`ifdef HAZ_FWD_EN
   // a load result is not on the bypass until it reaches slot LOAD_AVAIL
   assign hazard    = (hit_a && load_a && (int'(sel_a) < LOAD_AVAIL)) ||
                      (hit_b && load_b && (int'(sel_b) < LOAD_AVAIL));
   assign new_fwd_a = sel_a;
   assign new_fwd_b = sel_b;
`else
   logic unused_fwd;
   assign unused_fwd = ^{sel_a, sel_b, load_a, load_b, LOAD_AVAIL[0]};
   assign hazard     = hit_a || hit_b;
   assign new_fwd_a  = '0;
   assign new_fwd_b  = '0;
`endif

   assign ex_busy     = (busy_q != '0);
   assign stall       = id_valid && !ex_flush && (hazard || ex_busy);
   assign issue       = id_valid && !ex_flush && !stall;
   assign ex_fwd_a    = fwd_a_q;
   assign ex_fwd_b    = fwd_b_q;
   assign wb_wen      = slots_q[DEPTH-1].valid && slots_q[DEPTH-1].wen;
   assign wb_dest     = slots_q[DEPTH-1].dest;
   assign stall_count = stall_count_q;

   always_comb begin
      slots_d = slots_q;
      if (ex_busy) begin
         // MUL parks in EX; the slot behind it drains as a bubble
         slots_d[1] = '0;
         for (int i = 2; i < DEPTH; i++) slots_d[i] = slots_q[i-1];
      end else begin
         for (int i = 1; i < DEPTH; i++) slots_d[i] = slots_q[i-1];
         slots_d[0] = issue ? dec.slot : '0;
      end

      busy_d = busy_q;
      if (issue && dec.is_mul) busy_d = BUSY_W'(MUL_LAT - 1);
      else if (busy_q != '0)   busy_d = busy_q - BUSY_W'(1);

      // selects belong to the instruction in EX, so they hold with it
      fwd_a_d = '0;
      fwd_b_d = '0;
      if (ex_busy) begin
         fwd_a_d = fwd_a_q;
         fwd_b_d = fwd_b_q;
      end else if (issue) begin
         fwd_a_d = new_fwd_a;
         fwd_b_d = new_fwd_b;
      end

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slots_q       <= '0;
         busy_q        <= '0;
         fwd_a_q       <= '0;
         fwd_b_q       <= '0;
         stall_count_q <= '0;
      end else begin
         slots_q       <= slots_d;
         busy_q        <= busy_d;
         fwd_a_q       <= fwd_a_d;
         fwd_b_q       <= fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: cycle table for hazard_scoreboard (DEPTH=3,
// LOAD_AVAIL=2, MUL_LAT=4) plus a reset-during-MUL sequence. Expected
// forwarding selects are queued when a row is driven and checked one cycle later.
module tb_hazard_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_ir;
   logic        ex_flush;
   logic        stall, issue, ex_busy, wb_wen;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic [4:0]  wb_dest;
   logic [31:0] stall_count;

   int tests = 0;
   int fails = 0;

   hazard_scoreboard #(.DEPTH(3), .LOAD_AVAIL(2), .MUL_LAT(4)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_ir(id_ir),
      .ex_flush(ex_flush), .stall(stall), .issue(issue),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_busy(ex_busy),
      .wb_wen(wb_wen), .wb_dest(wb_dest), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        v;
      logic [31:0] ir;
      logic        fl;
      logic        st;
      logic        is;
      logic        bz;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        ww;
      logic [4:0]  wd;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] fwd_q[$];

   function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 16'h0004};
   endfunction

   task automatic row(input logic v, input logic [31:0] ir, input logic fl,
                      input logic st, input logic is, input logic bz,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic ww, input logic [4:0] wd);
      vecs.push_back('{v, ir, fl, st, is, bz, fa, fb, ww, wd});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   logic [31:0] a1, a2, lw5, a6, mul7, a8, z0, a9, jal, a10, sw10, x1, x2, x3;
   int          exp_sc;
   logic [3:0]  efw;

   initial begin
      a1   = r_op(1, 2, 3, 6'h20);      // ADD r3,r1,r2
      a2   = r_op(3, 1, 4, 6'h22);      // SUB r4,r3,r1
      lw5  = i_op(6'h23, 1, 5);         // LW  r5,4(r1)
      a6   = r_op(5, 5, 6, 6'h20);      // ADD r6,r5,r5
      mul7 = r_op(1, 2, 7, 6'h18);      // MUL r7,r1,r2
      a8   = r_op(1, 2, 8, 6'h20);      // ADD r8,r1,r2
      z0   = r_op(1, 2, 0, 6'h20);      // ADD r0,r1,r2
      a9   = r_op(0, 0, 9, 6'h20);      // ADD r9,r0,r0
      jal  = {6'h03, 26'h10};           // JAL
      a10  = r_op(31, 0, 10, 6'h20);    // ADD r10,r31,r0
      sw10 = i_op(6'h2B, 1, 10);        // SW  r10,4(r1)
      x1   = r_op(7, 1, 3, 6'h20);      // ADD r3,r7,r1
      x2   = r_op(3, 7, 3, 6'h20);      // ADD r3,r3,r7
      x3   = r_op(3, 3, 14, 6'h20);     // ADD r14,r3,r3

      //   v  ir    fl st is bz fa fb ww wd    (fa/fb: selects seen next cycle)
`ifdef HAZ_FWD_EN
      row(1, a1,   0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a2,   0, 0, 1, 0, 1, 0, 0, 0);
      row(1, lw5,  0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a6,   0, 1, 0, 0, 0, 0, 1, 3);
      row(1, a6,   0, 0, 1, 0, 2, 2, 1, 4);
      row(1, mul7, 0, 0, 1, 0, 0, 0, 1, 5);
      row(1, a8,   0, 1, 0, 1, 0, 0, 0, 0);
      row(1, a8,   0, 1, 0, 1, 0, 0, 1, 6);
      row(1, a8,   0, 1, 0, 1, 0, 0, 0, 0);
      row(1, x1,   0, 0, 1, 0, 1, 0, 0, 0);
      row(1, x2,   0, 0, 1, 0, 1, 2, 0, 0);
      row(1, x3,   0, 0, 1, 0, 1, 1, 1, 7);
      row(1, lw5,  0, 0, 1, 0, 0, 0, 1, 3);
      row(1, a6,   1, 0, 0, 0, 0, 0, 1, 3);
      row(1, z0,   0, 0, 1, 0, 0, 0, 1, 14);
      row(1, a9,   0, 0, 1, 0, 0, 0, 1, 5);
      row(0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0,    0, 0, 0, 0, 0, 0, 1, 9);
`else
      row(1, a1,   0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a2,   0, 1, 0, 0, 0, 0, 0, 0);
      row(1, a2,   0, 1, 0, 0, 0, 0, 0, 0);
      row(1, a2,   0, 0, 1, 0, 0, 0, 1, 3);
      row(1, lw5,  0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a6,   0, 1, 0, 0, 0, 0, 0, 0);
      row(1, a6,   0, 1, 0, 0, 0, 0, 1, 4);
      row(1, a6,   0, 0, 1, 0, 0, 0, 1, 5);
      row(1, mul7, 0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a8,   0, 1, 0, 1, 0, 0, 0, 0);
      row(1, a8,   0, 1, 0, 1, 0, 0, 1, 6);
      row(1, a8,   0, 1, 0, 1, 0, 0, 0, 0);
      row(1, a8,   0, 0, 1, 0, 0, 0, 0, 0);
      row(1, lw5,  0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a6,   1, 0, 0, 0, 0, 0, 1, 7);
      row(1, z0,   0, 0, 1, 0, 0, 0, 1, 8);
      row(1, a9,   0, 0, 1, 0, 0, 0, 1, 5);
      row(0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0,    0, 0, 0, 0, 0, 0, 1, 9);
      row(1, jal,  0, 0, 1, 0, 0, 0, 0, 0);
      row(1, a10,  0, 1, 0, 0, 0, 0, 0, 0);
      row(1, a10,  0, 1, 0, 0, 0, 0, 0, 0);
      row(1, a10,  0, 0, 1, 0, 0, 0, 1, 31);
      row(1, sw10, 0, 1, 0, 0, 0, 0, 0, 0);
      row(0, sw10, 0, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0,    0, 0, 0, 0, 0, 0, 1, 10);
`endif

      reset    = 1'b1;
      id_valid = 1'b0;
      id_ir    = '0;
      ex_flush = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #3;
      chk("reset stall",       32'(stall),       0);
      chk("reset issue",       32'(issue),       0);
      chk("reset ex_busy",     32'(ex_busy),     0);
      chk("reset wb_wen",      32'(wb_wen),      0);
      chk("reset wb_dest",     32'(wb_dest),     0);
      chk("reset ex_fwd_a",    32'(ex_fwd_a),    0);
      chk("reset ex_fwd_b",    32'(ex_fwd_b),    0);
      chk("reset stall_count", stall_count,      0);

      @(posedge clock);
      #1;
      fwd_q.push_back(4'h0);
      exp_sc = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         id_valid = vecs[i].v;
         id_ir    = vecs[i].ir;
         ex_flush = vecs[i].fl;
         #3;
         chk($sformatf("row%0d stall", i),   32'(stall),   32'(vecs[i].st));
         chk($sformatf("row%0d issue", i),   32'(issue),   32'(vecs[i].is));
         chk($sformatf("row%0d ex_busy", i), 32'(ex_busy), 32'(vecs[i].bz));
         chk($sformatf("row%0d wb_wen", i),  32'(wb_wen),  32'(vecs[i].ww));
         chk($sformatf("row%0d wb_dest", i), 32'(wb_dest), 32'(vecs[i].wd));
         chk($sformatf("row%0d stall_count", i), stall_count, 32'(exp_sc));
         efw = fwd_q.pop_front();
         chk($sformatf("row%0d ex_fwd_a", i), 32'(ex_fwd_a), 32'(efw[3:2]));
         chk($sformatf("row%0d ex_fwd_b", i), 32'(ex_fwd_b), 32'(efw[1:0]));
         fwd_q.push_back({vecs[i].fa, vecs[i].fb});
         if (vecs[i].st) exp_sc++;
         @(posedge clock);
         #1;
      end

      id_valid = 1'b0;
      ex_flush = 1'b0;
      #3;
      efw = fwd_q.pop_front();
      chk("last ex_fwd_a", 32'(ex_fwd_a), 32'(efw[3:2]));
      chk("last ex_fwd_b", 32'(ex_fwd_b), 32'(efw[1:0]));
      chk("last stall_count", stall_count, 32'(exp_sc));

      // reset while a MUL is parked in EX
      @(posedge clock);
      #1;
      id_valid = 1'b1;
      id_ir    = mul7;
      #3;
      chk("mul issue", 32'(issue), 1);
      @(posedge clock);
      #1;
      id_valid = 1'b0;
      #3;
      chk("mul ex_busy", 32'(ex_busy), 1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      #3;
      chk("rst-mul ex_busy",     32'(ex_busy),  0);
      chk("rst-mul wb_wen",      32'(wb_wen),   0);
      chk("rst-mul stall_count", stall_count,   0);
      chk("rst-mul ex_fwd_a",    32'(ex_fwd_a), 0);
      id_valid = 1'b1;
      id_ir    = a8;
      #1;
      chk("rst-mul stall", 32'(stall), 0);
      chk("rst-mul issue", 32'(issue), 1);
      @(posedge clock);
      #1;
      id_valid = 1'b0;
      #3;
      chk("rst-mul busy stays 0", 32'(ex_busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
